// File: rtl/ps2_host_tx_pkg.sv
// ps2_host_tx_pkg: shared PS/2 host-transmit FSM states, command constants and frame builder.
package ps2_host_tx_pkg;
  typedef enum logic [2:0] {IDLE, INHIBIT, SEND, ACK, WAIT_IDLE} ps2_tx_state_e;
  localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
  localparam logic [7:0] PS2_CMD_ECHO     = 8'hEE;
  localparam logic [7:0] PS2_ACK_BYTE     = 8'hFA;
  // {stop, odd parity, data}; shifted out LSB first
  function automatic logic [9:0] ps2_frame(input logic [7:0] d);
    return {1'b1, ~^d, d};
  endfunction
endpackage

// File: rtl/ps2_sync_edge.sv
// ps2_sync_edge: 2-FF synchronizers for the PS/2 clock and data lines plus clock falling-edge detect.
module ps2_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic clk_pin,
  input  logic data_pin,
  output logic clk_sync,
  output logic data_sync,
  output logic clk_fall
);
  logic [2:0] clk_sr_q, clk_sr_d;
  logic [1:0] data_sr_q, data_sr_d;
  assign clk_sr_d  = {clk_sr_q[1:0], clk_pin};
  assign data_sr_d = {data_sr_q[0], data_pin};
  // idle bus is high, so reset to 1 to avoid a false edge on release
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      clk_sr_q  <= 3'b111;
      data_sr_q <= 2'b11;
    end else begin
      clk_sr_q  <= clk_sr_d;
      data_sr_q <= data_sr_d;
    end
  assign clk_sync  = clk_sr_q[1];
  assign data_sync = data_sr_q[1];
  assign clk_fall  = clk_sr_q[2] & ~clk_sr_q[1];
endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 command transmitter with request-to-send, ACK check and timeout.
module ps2_host_tx
  import ps2_host_tx_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_err,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);
  localparam int MAXC = INHIBIT_CYCLES > TIMEOUT_CYCLES ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CW = $clog2(MAXC + 1);
  ps2_tx_state_e state_q, state_d;
  logic [9:0] shift_q, shift_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic data_oe_q, data_oe_d;
  logic clk_s, data_s, clk_fall, timeout, nack, line_idle;
  ps2_sync_edge u_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .clk_pin   (ps2_clk_in),
    .data_pin  (ps2_data_in),
    .clk_sync  (clk_s),
    .data_sync (data_s),
    .clk_fall  (clk_fall)
  );
  assign timeout   = (state_q inside {SEND, ACK, WAIT_IDLE}) && cnt_q == CW'(TIMEOUT_CYCLES);
  assign nack      = state_q == ACK && clk_fall && data_s;
  assign line_idle = clk_s && data_s;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      cnt_q     <= '0;
      data_oe_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      cnt_q     <= cnt_d;
      data_oe_q <= data_oe_d;
    end
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    data_oe_d = data_oe_q;
    cnt_d     = state_q == IDLE ? '0 : cnt_q + CW'(1);
    case (state_q)
      IDLE: if (tx_valid) begin
        state_d = INHIBIT;
        shift_d = ps2_frame(tx_data);
      end
      INHIBIT: if (cnt_q == CW'(INHIBIT_CYCLES - 1)) begin
        state_d   = SEND;
        cnt_d     = '0;
        bit_cnt_d = '0;
        data_oe_d = 1'b1;
      end
      SEND: if (clk_fall) begin
        data_oe_d = ~shift_q[0];
        shift_d   = {1'b1, shift_q[9:1]};
        bit_cnt_d = bit_cnt_q + 4'd1;
        state_d   = bit_cnt_q == 4'd9 ? ACK : SEND;
      end
      ACK: if (clk_fall) state_d = data_s ? IDLE : WAIT_IDLE;
      WAIT_IDLE: if (line_idle) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (timeout) begin
      state_d   = IDLE;
      data_oe_d = 1'b0;
    end
  end
  always_comb begin
    tx_ready    = state_q == IDLE;
    ps2_clk_oe  = state_q == INHIBIT;
    ps2_data_oe = data_oe_q;
    tx_err      = timeout || nack;
    tx_done     = !timeout && state_q == WAIT_IDLE && line_idle;
  end
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: randomized PS/2 host-transmit bench with an open-collector device model.
module tb_ps2_host_tx;
  localparam int INH = 20;
  localparam int TMO = 200;
  logic clk = 1'b0;
  logic rst_n;
  logic [7:0] tx_data;
  logic tx_valid, tx_ready, tx_done, tx_err;
  logic ps2_clk_in, ps2_data_in, ps2_clk_oe, ps2_data_oe;
  logic dev_clk_low, dev_data_low;
  int checks = 0, errors = 0;
  int done_n = 0, err_n = 0, bad_n = 0;
  logic prev_p = 1'b0;
  always #5 clk = ~clk;
  assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_data_in = ~(ps2_data_oe | dev_data_low);
  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .tx_done     (tx_done),
    .tx_err      (tx_err),
    .ps2_clk_in  (ps2_clk_in),
    .ps2_data_in (ps2_data_in),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  // Reference frame: data LSB first, then odd parity (1 when the data has an even number of ones), then stop=1
  function automatic logic [9:0] frame_of(input logic [7:0] d);
    logic [9:0] f;
    f[7:0] = d;
    f[8]   = ($countones(d) % 2) == 0;
    f[9]   = 1'b1;
    return f;
  endfunction
  always @(negedge clk) begin
    if (tx_done) done_n++;
    if (tx_err) err_n++;
    if ((tx_done && tx_err) || (prev_p && (tx_done || tx_err || !tx_ready))) bad_n++;
    prev_p = tx_done | tx_err;
  end
  // Device: generate clock pulses, sample host data on each rising edge, optionally pull data low for ACK
  task automatic dev_clock(input int npulse, input bit ack, output logic [9:0] bits);
    int h;
    bits = '0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < npulse; i++) begin
      h = $urandom_range(4, 6);
      if (i == 10) begin
        dev_data_low = ack;
        repeat (2) @(negedge clk);
      end
      dev_clk_low = 1'b1;
      repeat (h) @(negedge clk);
      dev_clk_low = 1'b0;
      if (i < 10) bits[i] = ps2_data_in;
      repeat (h) @(negedge clk);
    end
    dev_data_low = 1'b0;
  endtask
  task automatic start_tx(input logic [7:0] d);
    int n;
    @(negedge clk);
    check("ready_idle", tx_ready, 1);
    tx_data = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    n = 0;
    while (ps2_clk_oe && n < 1000) begin
      n++;
      @(negedge clk);
    end
    check("inhibit_len", n, INH);
    check("start_bit", ps2_data_oe, 1);
  endtask
  task automatic send(input logic [7:0] d, input bit ack, input bit tmo);
    logic [9:0] bits;
    int n;
    done_n = 0;
    err_n = 0;
    bad_n = 0;
    start_tx(d);
    if (tmo) begin
      n = 0;
      while (!tx_err && n < 1000) begin
        n++;
        @(negedge clk);
      end
      check("timeout_len", n, TMO);
      @(negedge clk);
    end else begin
      dev_clock(11, ack, bits);
      check("frame_bits", bits, frame_of(d));
      n = 0;
      while (done_n + err_n == 0 && n < 200) begin
        n++;
        @(negedge clk);
      end
    end
    repeat (2) @(negedge clk);
    check("done_cnt", done_n, (ack && !tmo) ? 1 : 0);
    check("err_cnt", err_n, (ack && !tmo) ? 0 : 1);
    check("pulse_shape", bad_n, 0);
    check("clk_released", ps2_clk_oe, 0);
    check("data_released", ps2_data_oe, 0);
    check("ready_after", tx_ready, 1);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [9:0] bits, exp_f;
    rst_n = 1'b0;
    tx_valid = 1'b0;
    tx_data = '0;
    dev_clk_low = 1'b0;
    dev_data_low = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready", tx_ready, 1);
    check("rst_done", tx_done, 0);
    check("rst_err", tx_err, 0);
    check("rst_clk_oe", ps2_clk_oe, 0);
    check("rst_data_oe", ps2_data_oe, 0);
    rst_n = 1'b1;
    send(8'hED, 1, 0);
    send(8'h01, 1, 0);
    send(8'hFF, 1, 0);
    for (int i = 0; i < 6; i++) send(8'($urandom_range(0, 255)), 1, 0);
    send(8'($urandom_range(0, 255)), 0, 0);
    send(8'hA5, 1, 1);
    // Reset mid-frame after the 4th bit; D3 of 0xE5 is 0 so data is being pulled low
    done_n = 0;
    err_n = 0;
    start_tx(8'hE5);
    dev_clock(4, 0, bits);
    exp_f = frame_of(8'hE5);
    check("partial_bits", bits[3:0], exp_f[3:0]);
    tx_data = 8'h55;
    tx_valid = 1'b1;
    @(negedge clk);
    check("busy_ready", tx_ready, 0);
    check("pre_rst_data_oe", ps2_data_oe, 1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_clk_oe", ps2_clk_oe, 0);
    check("rst_mid_data_oe", ps2_data_oe, 0);
    tx_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("rst_mid_pulses", done_n + err_n, 0);
    send(8'hEE, 1, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) from the core to the keyboard over the open-collector PS/2 clock/data lines. It is the counterpart of the scancode receive/decode path. It performs the request-to-send sequence, shifts out data, parity and stop bits on device clock edges, and checks the device ACK.

## Interface
- INHIBIT_CYCLES, 5000: system clocks PS/2 clock is held low (100 µs at 50 MHz)
- TIMEOUT_CYCLES, 750000: max system clocks from clock release to ACK-complete (15 ms at 50 MHz)
- clk  in  1  system clock; single clock domain
- rst_n  in  1  asynchronous, active-low reset
- tx_data  in  8  command byte, sampled when tx_valid && tx_ready
- tx_valid  in  1  request to send tx_data
- tx_ready  out  1  high only in IDLE
- tx_done  out  1  one-cycle pulse: frame complete, ACK received
- tx_err  out  1  one-cycle pulse: no ACK (data high at 11th edge) or timeout
- ps2_clk_in  in  1  raw PS/2 clock line (asynchronous)
- ps2_data_in  in  1  raw PS/2 data line (asynchronous)
- ps2_clk_oe  out  1  1 = pull PS/2 clock low; 0 = release
- ps2_data_oe  out  1  1 = pull PS/2 data low; 0 = release

## Operation
- Reset values: tx_ready=1, tx_done=0, tx_err=0, ps2_clk_oe=0, ps2_data_oe=0, state IDLE, counters 0.
- ps2_clk_in and ps2_data_in pass through 2-FF synchronizers; falling edge = previous synced clk 1, current 0.
- Frame latched on accept: shift register {stop=1, parity=~^tx_data, tx_data}; parity is odd.
- States:
  - IDLE: tx_ready=1, lines released. tx_valid -> latch, go INHIBIT.
  - INHIBIT: clk_oe=1 for INHIBIT_CYCLES clocks; then data_oe=1 (start bit), clk_oe=0, go SEND, bit count 0, timeout counter cleared.
  - SEND: on each device falling edge present next bit: data_oe = ~bit (LSB first D0..D7, parity, stop). On the 10th edge the stop bit releases data; go ACK.
  - ACK: at next (11th) falling edge sample synced data: 0 -> WAIT_IDLE; 1 -> pulse tx_err, go IDLE.
  - WAIT_IDLE: wait until synced clk and data are both 1, then pulse tx_done, go IDLE.
- Timeout counter runs in SEND, ACK and WAIT_IDLE; reaching TIMEOUT_CYCLES releases both lines, pulses tx_err, returns to IDLE. tx_done and tx_err are never asserted together.
- tx_valid outside IDLE is ignored (not queued).
- Reset mid-frame: both lines released immediately (async), frame discarded.

## Timing
- Accept at cycle 0; clk_oe high on cycles 1..INHIBIT_CYCLES; data_oe asserts and clk_oe drops in the same cycle.
- Falling-edge detection lags the pin by 3 clk cycles (2 sync + edge register); data_oe updates 1 cycle after detection. This is well inside the 5 µs device setup window.
- tx_done/tx_err last exactly one clk cycle; tx_ready returns high in the cycle after the pulse.
- Counters wide enough for max(INHIBIT_CYCLES, TIMEOUT_CYCLES) via $clog2.

## Structure
- Shared PS/2 package: state enum, PS2_CMD_SET_LEDS=8'hED, PS2_CMD_RESET=8'hFF, PS2_CMD_ECHO=8'hEE, PS2_ACK_BYTE=8'hFA.
- One sub-module: ps2_sync_edge (2-FF synchronizer + falling-edge detect). It is shareable with the receive path.
- Intended size ~150–250 lines RTL.

## Test plan
- Send 0xED with device model ACKing: bench samples bits 1,0,1,1,0,1,1,1 (LSB first), parity 1, stop 1 -> one tx_done pulse, tx_err 0, lines released.
- Send 0x01: data bits 1,0,0,0,0,0,0,0, parity 0 -> tx_done. Send 0xFF: parity 1 -> tx_done.
- Clock inhibit: INHIBIT_CYCLES=20 -> clk_oe high exactly 20 cycles, data_oe rises in the cycle clk_oe falls.
- Device leaves data high at the 11th edge -> tx_err pulse, no tx_done, back to IDLE with tx_ready=1.
- Device never clocks, TIMEOUT_CYCLES=200 -> tx_err exactly 200 cycles after clock release, both oe=0.
- Assert rst_n low after the 4th bit -> clk_oe=data_oe=0 immediately; second tx_valid during SEND ignored; after reset a 0xEE send completes normally.
